// File: rtl/sw_buff_sector_drainer.sv
// sw_buff_sector_drainer
// Read side of the 1024 x 8 sector ping-pong buffer. Watches the pump status
// for a newly completed half, reads that half's SECTOR_BYTES bytes and streams
// them to the sector writer over a valid/ready byte interface, then releases
// the half back to the pump through BUFWAITING.
//
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   ENA              synchronous block enable; low abandons the current sector
//   BUFREADY_PUMP    pump status, a change to 01/10 marks a completed half
//   BUFWAITING       release handshake, 01 = lower released, 10 = upper
//   RADDR_SW/RCLK_SW/RENA_SW/Q_SW  synchronous buffer read port
//   SECT_DATA/VALID/READY/FIRST/LAST  byte stream towards the sector writer
//   SECTORS_WRITTEN  count of released halves (wraps)
//   BUSY             high while draining, flushing or releasing
//   OVERRUN          sticky: a completed half was dropped
module sw_buff_sector_drainer #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENA,
  input  logic [1:0]        BUFREADY_PUMP,
  output logic [1:0]        BUFWAITING,
  output logic [ADDR_W-1:0] RADDR_SW,
  output logic              RCLK_SW,
  output logic              RENA_SW,
  input  logic [7:0]        Q_SW,
  output logic [7:0]        SECT_DATA,
  output logic              SECT_VALID,
  input  logic              SECT_READY,
  output logic              SECT_FIRST,
  output logic              SECT_LAST,
  output logic [31:0]       SECTORS_WRITTEN,
  output logic              BUSY,
  output logic              OVERRUN
);

  localparam int CNT_W = $clog2(SECTOR_BYTES);
  localparam logic [CNT_W-1:0] RCNT_MAX = CNT_W'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DRAIN, S_FLUSH, S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        prev_ready_q, prev_ready_d;
  logic              half_q, half_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              pend_q, pend_d;
  logic              pend_half_q, pend_half_d;
  logic              overrun_q, overrun_d;
  logic [1:0]        bufwaiting_q, bufwaiting_d;
  logic [31:0]       sectors_written_q, sectors_written_d;

  // Read in flight: RAM has latched the address, Q_SW is valid this cycle.
  logic              rd_vld_p1_q, rd_vld_p1_d;
  logic              rd_first_p1_q, rd_first_p1_d;
  logic              rd_last_p1_q, rd_last_p1_d;

  // Two-entry output FIFO; the head drives the stream directly.
  logic [7:0]        fifo_data_q [2];
  logic [7:0]        fifo_data_d [2];
  logic              fifo_first_q [2];
  logic              fifo_first_d [2];
  logic              fifo_last_q [2];
  logic              fifo_last_d [2];
  logic              fifo_wptr_q, fifo_wptr_d;
  logic              fifo_rptr_q, fifo_rptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              pump_change;
  logic              new_half;
  logic              sect_valid;
  logic              pop;
  logic [2:0]        occ;
  logic              issue;

  assign pump_change = (BUFREADY_PUMP != prev_ready_q) &&
                       ((BUFREADY_PUMP == 2'b01) || (BUFREADY_PUMP == 2'b10));
  assign new_half    = BUFREADY_PUMP[1];
  assign sect_valid  = (fifo_cnt_q != 2'd0);
  assign pop         = sect_valid & SECT_READY;

  // Credit check counts the byte leaving this cycle so that a steady
  // ready sink sees one read per cycle without ever overfilling the FIFO.
  assign occ   = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, rd_vld_p1_q};
  assign issue = (state_q == S_DRAIN) && (occ < 3'd2);

  always_comb begin
    state_d           = state_q;
    prev_ready_d      = prev_ready_q;
    half_d            = half_q;
    rcnt_d            = rcnt_q;
    pend_d            = pend_q;
    pend_half_d       = pend_half_q;
    overrun_d         = overrun_q;
    bufwaiting_d      = bufwaiting_q;
    sectors_written_d = sectors_written_q;
    rd_vld_p1_d       = 1'b0;
    rd_first_p1_d     = rd_first_p1_q;
    rd_last_p1_d      = rd_last_p1_q;
    fifo_data_d       = fifo_data_q;
    fifo_first_d      = fifo_first_q;
    fifo_last_d       = fifo_last_q;
    fifo_wptr_d       = fifo_wptr_q;
    fifo_rptr_d       = fifo_rptr_q;
    fifo_cnt_d        = fifo_cnt_q;

    if (!ENA) begin
      state_d     = S_IDLE;
      pend_d      = 1'b0;
      fifo_wptr_d = 1'b0;
      fifo_rptr_d = 1'b0;
      fifo_cnt_d  = 2'd0;
    end else begin
      prev_ready_d = BUFREADY_PUMP;

      if (rd_vld_p1_q) begin
        fifo_data_d[fifo_wptr_q]  = Q_SW;
        fifo_first_d[fifo_wptr_q] = rd_first_p1_q;
        fifo_last_d[fifo_wptr_q]  = rd_last_p1_q;
        fifo_wptr_d               = ~fifo_wptr_q;
      end
      if (pop) begin
        fifo_rptr_d = ~fifo_rptr_q;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, rd_vld_p1_q} - {1'b0, pop};

      rd_vld_p1_d = issue;
      if (issue) begin
        rd_first_p1_d = (rcnt_q == '0);
        rd_last_p1_d  = (rcnt_q == RCNT_MAX);
      end

      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (pump_change) begin
            half_d  = new_half;
            rcnt_d  = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (issue) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == RCNT_MAX) state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (pop && fifo_last_q[fifo_rptr_q]) begin
            bufwaiting_d      = half_q ? 2'b10 : 2'b01;
            sectors_written_d = sectors_written_q + 32'd1;
            state_d           = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (pend_q) begin
            half_d  = pend_half_q;
            rcnt_d  = '0;
            pend_d  = 1'b0;
            state_d = S_DRAIN;
          end else if (pump_change) begin
            half_d  = new_half;
            rcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A completed half arriving while busy is parked in the single pending
      // slot. In RELEASE the slot is being consumed, so it can take a new one.
      if (pump_change && ((state_q == S_DRAIN) || (state_q == S_FLUSH) ||
                          ((state_q == S_RELEASE) && pend_q))) begin
        if (pend_q && (state_q != S_RELEASE)) begin
          overrun_d = 1'b1;
        end else begin
          pend_d      = 1'b1;
          pend_half_d = new_half;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= S_IDLE;
      prev_ready_q      <= 2'b00;
      half_q            <= 1'b0;
      rcnt_q            <= '0;
      pend_q            <= 1'b0;
      pend_half_q       <= 1'b0;
      overrun_q         <= 1'b0;
      bufwaiting_q      <= 2'b00;
      sectors_written_q <= 32'd0;
      rd_vld_p1_q       <= 1'b0;
      rd_first_p1_q     <= 1'b0;
      rd_last_p1_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i]  <= 8'd0;
        fifo_first_q[i] <= 1'b0;
        fifo_last_q[i]  <= 1'b0;
      end
      fifo_wptr_q       <= 1'b0;
      fifo_rptr_q       <= 1'b0;
      fifo_cnt_q        <= 2'd0;
    end else begin
      state_q           <= state_d;
      prev_ready_q      <= prev_ready_d;
      half_q            <= half_d;
      rcnt_q            <= rcnt_d;
      pend_q            <= pend_d;
      pend_half_q       <= pend_half_d;
      overrun_q         <= overrun_d;
      bufwaiting_q      <= bufwaiting_d;
      sectors_written_q <= sectors_written_d;
      rd_vld_p1_q       <= rd_vld_p1_d;
      rd_first_p1_q     <= rd_first_p1_d;
      rd_last_p1_q      <= rd_last_p1_d;
      fifo_data_q       <= fifo_data_d;
      fifo_first_q      <= fifo_first_d;
      fifo_last_q       <= fifo_last_d;
      fifo_wptr_q       <= fifo_wptr_d;
      fifo_rptr_q       <= fifo_rptr_d;
      fifo_cnt_q        <= fifo_cnt_d;
    end
  end

  assign RCLK_SW         = CLK;
  assign RENA_SW         = issue;
  assign RADDR_SW        = ADDR_W'({half_q, rcnt_q});
  assign SECT_DATA       = fifo_data_q[fifo_rptr_q];
  assign SECT_VALID      = sect_valid;
  assign SECT_FIRST      = sect_valid & fifo_first_q[fifo_rptr_q];
  assign SECT_LAST       = sect_valid & fifo_last_q[fifo_rptr_q];
  assign BUFWAITING      = bufwaiting_q;
  assign SECTORS_WRITTEN = sectors_written_q;
  assign BUSY            = (state_q == S_DRAIN) || (state_q == S_FLUSH) ||
                           (state_q == S_RELEASE);
  assign OVERRUN         = overrun_q;

endmodule
